scan_collector: RTL and testbench
=================================

SCAN_COLLECTOR -- requirements
Module: scan_collector

Interface
REQ-001 clk  input  1  single system clock; all logic samples on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 enable  input  1  operator enable; drives scanner `active` through this block.
REQ-004 permit_allowed  input  1  ground/link grants permission to accept payload.
REQ-005 flush_req  input  1  operator request to discard scanner buffer.
REQ-006 transfer_data  input  1  serial bit from scanner, MSB first.
REQ-007 transfer_clock  input  1  bit strobe; a bit is valid on any clk edge where this is high.
REQ-008 transfer_ready  output  1  collector can accept a bit this cycle.
REQ-009 active  output  1  registered copy of enable.
REQ-010 transfer_permit  output  1  permission for scanner to send payload.
REQ-011 flush  output  1  one-cycle flush pulse to scanner.
REQ-012 byte_out  output  8  deserialized payload byte.
REQ-013 byte_valid  output  1  byte_out valid; held until byte_accept.
REQ-014 byte_accept  input  1  downstream consumes byte_out when byte_valid && byte_accept.
REQ-015 level  output  3  last status: 0 none, 1 50%, 2 80%, 3 90%, 4 full.
REQ-016 payload_count  output  8  payload bytes delivered, 0..128.
REQ-017 done  output  1  high once 128 payload bytes delivered.
REQ-018 err_count  output  4  unknown-code count, saturating at 15.

Function
REQ-019 Bit accepted iff transfer_clock && transfer_ready at a clk edge; shifted in MSB first; 3-bit bit counter wraps 7->0 and completes a byte.
REQ-020 transfer_ready = active && !(byte_valid && !byte_accept) && state != DONE.
REQ-021 States: HDR (8-bit status codes), PAYLOAD, DONE; reset state HDR.
REQ-022 HDR byte decode: 1/2/3/4 -> level set to that code; 7 -> enter PAYLOAD next cycle, bit counter cleared; any other -> err_count+1 (saturating), level unchanged.
REQ-023 transfer_permit rises the cycle after level>=2 && permit_allowed, holds until code 7 decoded, then falls; deasserting permit_allowed before code 7 clears it next cycle.
REQ-024 flush pulses one cycle when flush_req && level==4 && !transfer_permit && state==HDR; flush_req otherwise ignored; after flush, level returns to 0.
REQ-025 PAYLOAD: each completed byte loaded into byte_out, byte_valid set on the next edge; payload_count increments on each byte_valid && byte_accept handshake.
REQ-026 Byte completion and handshake in the same cycle: old byte retires, new byte loads, byte_valid stays high.
REQ-027 payload_count reaching 128 -> state DONE, done=1, level=0; DONE returns to HDR on the first edge with enable low.
REQ-028 enable low in PAYLOAD: active falls next cycle, ready falls, partial byte and counters retained; resume on enable high without loss.
REQ-029 Latency: last bit of byte accepted at edge N -> byte_valid high after edge N+1.

Reset
REQ-030 On rst all state clears: state HDR, active 0, transfer_ready 0, transfer_permit 0, flush 0, byte_out 0, byte_valid 0, level 0, payload_count 0, done 0, err_count 0, shift register and bit counter 0.
REQ-031 rst mid-PAYLOAD discards any partial byte and pending byte_valid; no handshake completes on the reset edge.

Structure
REQ-032 Shared package holds the status codes (1,2,3,4,7), PAYLOAD_BYTES=128, and the state encoding.
REQ-033 One sub-module, serial_deser: 8-bit MSB-first shifter, bit counter, byte-complete strobe, and synchronous clear.

Verification
REQ-034 Enable high, send codes 1,2 with permit_allowed=1 -> level=2, transfer_permit high one cycle after the code-2 byte completes.
REQ-035 Send 7 then 128 bytes 0x00..0x7F with byte_accept=1 -> byte_out sequence matches, payload_count=128, done=1, transfer_permit low.
REQ-036 Hold byte_accept=0 during payload -> transfer_ready low while byte_valid; no bit lost; data intact after release.
REQ-037 Send code 4, then flush_req with permit_allowed=0 -> exactly one flush pulse, level=0.
REQ-038 Send code 0x55 -> err_count=1, level unchanged; after 16 bad codes err_count=15.
REQ-039 Assert rst after 3 bits of payload byte 10 -> all outputs at reset values the next cycle, state HDR.

Source files
------------

// File: rtl/scan_collector_pkg.sv
// scan_collector_pkg: status codes, payload size and state encoding shared by the collector.
package scan_collector_pkg;
    localparam logic [7:0] CODE_L50     = 8'd1;
    localparam logic [7:0] CODE_L80     = 8'd2;
    localparam logic [7:0] CODE_L90     = 8'd3;
    localparam logic [7:0] CODE_FULL    = 8'd4;
    localparam logic [7:0] CODE_PAYLOAD = 8'd7;
    localparam int PAYLOAD_BYTES = 128;
    localparam logic [1:0] ST_HDR     = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
endpackage

// File: rtl/scan_collector_serial_deser.sv
// serial_deser: MSB-first 8-bit shifter with bit counter and registered byte-complete strobe.
module serial_deser (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       din,
    output logic [7:0] data,
    output logic       byte_done
);
    logic [2:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data      <= '0;
            cnt       <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= shift_en && cnt == 3'd7;
            if (shift_en) begin
                data <= {data[6:0], din};
                cnt  <= cnt + 3'd1;
            end
        end
    end
endmodule

// File: rtl/scan_collector.sv
// scan_collector: decodes scanner status codes, gates payload permission and deserializes 128 payload bytes.
module scan_collector
    import scan_collector_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       permit_allowed,
    input  logic       flush_req,
    input  logic       transfer_data,
    input  logic       transfer_clock,
    output logic       transfer_ready,
    output logic       active,
    output logic       transfer_permit,
    output logic       flush,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_accept,
    output logic [2:0] level,
    output logic [7:0] payload_count,
    output logic       done,
    output logic [3:0] err_count
);
    logic [1:0] state;
    logic [7:0] sr;
    logic byte_done, hdr_done, dec7, lvl_code, bad, hs, last, flush_go, permit_n, leave_done;
    assign transfer_ready = active && !(byte_valid && !byte_accept) && state != ST_DONE;
    assign hdr_done   = byte_done && state == ST_HDR;
    assign dec7       = hdr_done && sr == CODE_PAYLOAD;
    assign lvl_code   = hdr_done && sr inside {CODE_L50, CODE_L80, CODE_L90, CODE_FULL};
    assign bad        = hdr_done && !dec7 && !lvl_code;
    assign hs         = byte_valid && byte_accept;
    assign last       = hs && payload_count == 8'(PAYLOAD_BYTES - 1);
    assign flush_go   = flush_req && level == 3'd4 && !transfer_permit && state == ST_HDR && !flush;
    assign permit_n   = state == ST_HDR && !dec7 && permit_allowed && (transfer_permit || level >= 3'd2);
    assign leave_done = state == ST_DONE && !enable;

    serial_deser u_deser (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush_go),
        .shift_en (transfer_clock && transfer_ready),
        .din      (transfer_data),
        .data     (sr),
        .byte_done(byte_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_HDR;
            active          <= 1'b0;
            transfer_permit <= 1'b0;
            flush           <= 1'b0;
            byte_out        <= '0;
            byte_valid      <= 1'b0;
            level           <= '0;
            payload_count   <= '0;
            done            <= 1'b0;
            err_count       <= '0;
        end else begin
            active          <= enable;
            flush           <= flush_go;
            transfer_permit <= permit_n;
            state <= dec7 ? ST_PAYLOAD : last ? ST_DONE : leave_done ? ST_HDR : state;
            level <= lvl_code ? sr[2:0] : (flush_go || last) ? 3'd0 : level;
            if (bad && err_count != 4'd15) err_count <= err_count + 4'd1;
            // a byte landing in the handshake cycle keeps byte_valid high
            if (byte_done && state == ST_PAYLOAD) begin
                byte_out   <= sr;
                byte_valid <= 1'b1;
            end else if (hs) byte_valid <= 1'b0;
            payload_count <= leave_done ? 8'd0 : hs ? payload_count + 8'd1 : payload_count;
            done <= last ? 1'b1 : leave_done ? 1'b0 : done;
        end
    end
endmodule

// File: tb/tb_scan_collector.sv
// tb_scan_collector: directed checks of header decode, permit, flush, payload, backpressure and reset.
module tb_scan_collector;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, permit_allowed = 1'b0, flush_req = 1'b0;
    logic tdata = 1'b0, tclk = 1'b0, byte_accept = 1'b0;
    logic transfer_ready, active, transfer_permit, flush, byte_valid, done;
    logic [7:0] byte_out, payload_count;
    logic [2:0] level;
    logic [3:0] err_count;
    int passed = 0, total = 0, pulses;

    scan_collector dut (
        .clk(clk), .rst(rst), .enable(enable), .permit_allowed(permit_allowed),
        .flush_req(flush_req), .transfer_data(tdata), .transfer_clock(tclk),
        .transfer_ready(transfer_ready), .active(active), .transfer_permit(transfer_permit),
        .flush(flush), .byte_out(byte_out), .byte_valid(byte_valid), .byte_accept(byte_accept),
        .level(level), .payload_count(payload_count), .done(done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        tdata = b;
        tclk = 1'b1;
        for (int k = 0; k < 50 && !transfer_ready; k++) @(negedge clk);
        check("ready_for_bit", transfer_ready, 1);
        @(posedge clk);
        #1 tclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_active", active, 0);
        check("rst_ready", transfer_ready, 0);
        check("rst_permit", transfer_permit, 0);
        check("rst_flush", flush, 0);
        check("rst_byte_out", byte_out, 0);
        check("rst_valid", byte_valid, 0);
        check("rst_level", level, 0);
        check("rst_count", payload_count, 0);
        check("rst_done", done, 0);
        check("rst_err", err_count, 0);
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("active_on", active, 1);
        check("ready_on", transfer_ready, 1);
        permit_allowed = 1'b1;
        send_byte(8'd1);
        repeat (2) @(negedge clk);
        check("level_1", level, 1);
        check("permit_lvl1", transfer_permit, 0);
        send_byte(8'd2);
        repeat (2) @(negedge clk);
        check("level_2", level, 2);
        check("permit_not_yet", transfer_permit, 0);
        @(negedge clk);
        check("permit_rise", transfer_permit, 1);
        send_byte(8'd7);
        repeat (2) @(negedge clk);
        check("permit_fall_on_7", transfer_permit, 0);
        byte_accept = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if (i == 5) begin
                @(negedge clk);
                byte_accept = 1'b0;
            end
            send_byte(8'(i));
            repeat (2) @(negedge clk);
            check("payload_valid", byte_valid, 1);
            check("payload_byte", byte_out, 32'(i));
            if (i == 5) begin
                check("stall_ready", transfer_ready, 0);
                tclk = 1'b1;
                tdata = 1'b1;
                repeat (3) @(negedge clk);
                check("stall_ready_held", transfer_ready, 0);
                check("stall_valid_held", byte_valid, 1);
                check("stall_byte_held", byte_out, 5);
                check("stall_count", payload_count, 5);
                tclk = 1'b0;
                byte_accept = 1'b1;
                @(negedge clk);
                check("release_count", payload_count, 6);
                check("release_valid", byte_valid, 0);
            end
        end
        @(negedge clk);
        check("final_count", payload_count, 128);
        check("done_set", done, 1);
        check("done_permit", transfer_permit, 0);
        check("done_level", level, 0);
        check("done_ready", transfer_ready, 0);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("hdr_ready", transfer_ready, 1);
        send_byte(8'd4);
        repeat (3) @(negedge clk);
        check("level_full", level, 4);
        check("permit_full", transfer_permit, 1);
        flush_req = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(flush);
        end
        check("no_flush_with_permit", pulses, 0);
        permit_allowed = 1'b0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(flush);
        end
        flush_req = 1'b0;
        check("flush_pulses", pulses, 1);
        check("flush_level", level, 0);
        check("flush_permit", transfer_permit, 0);
        send_byte(8'h55);
        repeat (2) @(negedge clk);
        check("err_1", err_count, 1);
        check("err_level", level, 0);
        for (int i = 0; i < 15; i++) send_byte(8'h55 ^ 8'(i << 4));
        repeat (2) @(negedge clk);
        check("err_sat", err_count, 15);
        send_byte(8'd7);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(8'hA0 + i));
            repeat (2) @(negedge clk);
            check("s2_byte", byte_out, 32'(8'hA0 + i));
        end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("s2_count", payload_count, 10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_active", active, 0);
        check("mid_rst_ready", transfer_ready, 0);
        check("mid_rst_byte", byte_out, 0);
        check("mid_rst_valid", byte_valid, 0);
        check("mid_rst_count", payload_count, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'd3);
        repeat (2) @(negedge clk);
        check("post_rst_hdr_level", level, 3);
        check("post_rst_err", err_count, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
